tetris_game_sequencer: RTL and testbench

//  Top-level game-flow controller for the falling-piece mover: spawns pieces, issues fall ticks
//  at a level-dependent rate, and locks the piece when it lands. After a lock it scans the board

---
 rtl/tetris_pkg.sv | 40 ++++
 rtl/tetris_shape_lfsr.sv | 38 +++
 rtl/tetris_game_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_tetris_game_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece game-flow controller.
// The optional soft-drop speed-up is enabled by defining TETRIS_SOFT_DROP_EN.
package tetris_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    SPAWN_CHK,
    FALL,
    LOCK,
    SCAN,
    CLEAR,
    GAME_OVER
  } state_t;

  localparam logic [3:0]  SHAPE_MIN  = 4'd1;
  localparam logic [3:0]  SHAPE_MAX  = 4'd14;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci register map to bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS  = 16'h002D;
  localparam int          BLOCK_SIZE = 20;

  // Folds the two unused nibble codes onto valid shapes.
  function automatic logic [3:0] shape_from_nibble(input logic [3:0] v);
    if (v == 4'd0)  return SHAPE_MAX;
    if (v == 4'd15) return SHAPE_MIN;
    return v;
  endfunction

  function automatic logic [31:0] fall_period(input logic [3:0]  lvl,
                                              input logic [31:0] base,
                                              input logic [31:0] step,
                                              input logic [31:0] floor_p);
    logic [31:0] drop;
    drop = ({28'd0, lvl} - 32'd1) * step;
    if (drop >= base || (base - drop) < floor_p) return floor_p;
    return base - drop;
  endfunction

endpackage

// File: rtl/tetris_shape_lfsr.sv
// Pseudo-random shape source: 16-bit Fibonacci LFSR, advanced once per spawn.
// shape_id reflects the current register contents combinationally.
module tetris_shape_lfsr
  import tetris_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic       iVGA_CLK,
  input  logic       reset,
  input  logic       advance,
  output logic [3:0] shape_id
);

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic        feedback;

  assign feedback = ^(lfsr_reg & LFSR_TAPS);

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_shift
      assign lfsr_next[gi] = lfsr_reg[gi+1];
    end
  endgenerate
  assign lfsr_next[15] = feedback;

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      lfsr_reg <= SEED;
    end else if (advance) begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign shape_id = shape_from_nibble(lfsr_reg[3:0]);

endmodule

// File: rtl/tetris_game_sequencer.sv
// Game-flow controller: spawn, timed fall ticks, lock, bottom-up row-clear scan, scoring.
// Define TETRIS_SOFT_DROP_EN to let an active-low soft_drop shorten the fall period by 8x.
module tetris_game_sequencer
  import tetris_pkg::*;
#(
  parameter int unsigned TICK_BASE       = 4500000,
  parameter int unsigned TICK_STEP       = 300000,
  parameter int unsigned TICK_MIN        = 600000,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL       = 15,
  parameter int unsigned NUM_ROWS        = 24
) (
  input  logic        iVGA_CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        landed,
  input  logic        spawn_blocked,
  input  logic        row_full,
  input  logic        clear_ack,
  input  logic        soft_drop,
  output logic        spawn,
  output logic [3:0]  shape_id,
  output logic        fall_tick,
  output logic        lock,
  output logic [4:0]  scan_row,
  output logic        clear_row,
  output logic [15:0] lines,
  output logic [3:0]  level,
  output logic        game_over
);

  localparam logic [4:0]  BOTTOM_ROW = 5'(NUM_ROWS - 1);
  localparam logic [15:0] LVL_WRAP   = 16'(LINES_PER_LEVEL - 1);
  localparam logic [3:0]  LVL_TOP    = 4'(MAX_LEVEL);

  state_t      state_reg;
  logic [31:0] tick_cnt_reg;
  logic [31:0] thresh_reg;
  logic [15:0] lvl_cnt_reg;
  logic [15:0] lines_reg;
  logic [3:0]  level_reg;
  logic [4:0]  scan_row_reg;
  logic [3:0]  shape_id_reg;
  logic        spawn_reg, fall_tick_reg, lock_reg, clear_row_reg, game_over_reg;
  logic [3:0]  lfsr_shape;
  logic [31:0] period_now;
  logic [31:0] thresh_now;

  tetris_shape_lfsr #(.SEED(LFSR_SEED)) u_shape_lfsr (
    .iVGA_CLK (iVGA_CLK),
    .reset    (reset),
    .advance  (state_reg == SPAWN),
    .shape_id (lfsr_shape)
  );

  assign period_now = fall_period(level_reg, TICK_BASE, TICK_STEP, TICK_MIN);

`ifdef TETRIS_SOFT_DROP_EN
  always_comb begin
    thresh_now = period_now;
    if (!soft_drop) begin
      thresh_now = ((period_now >> 3) == 32'd0) ? 32'd1 : (period_now >> 3);
    end
  end
`else
  logic unused_soft_drop;
  assign unused_soft_drop = soft_drop;
  assign thresh_now       = period_now;
`endif

  // The threshold is latched at FALL entry and at each wrap so a level or
  // button change never truncates the tick already in progress.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      tick_cnt_reg  <= '0;
      thresh_reg    <= 32'(TICK_BASE);
      lvl_cnt_reg   <= '0;
      lines_reg     <= '0;
      level_reg     <= 4'd1;
      scan_row_reg  <= BOTTOM_ROW;
      shape_id_reg  <= SHAPE_MIN;
      spawn_reg     <= 1'b0;
      fall_tick_reg <= 1'b0;
      lock_reg      <= 1'b0;
      clear_row_reg <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      spawn_reg     <= 1'b0;
      fall_tick_reg <= 1'b0;
      lock_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= SPAWN;
            spawn_reg    <= 1'b1;
            shape_id_reg <= lfsr_shape;
          end
        end
        SPAWN: state_reg <= SPAWN_CHK;
        SPAWN_CHK: begin
          if (spawn_blocked) begin
            state_reg     <= GAME_OVER;
            game_over_reg <= 1'b1;
          end else begin
            state_reg    <= FALL;
            tick_cnt_reg <= '0;
            thresh_reg   <= thresh_now;
          end
        end
        FALL: begin
          if (tick_cnt_reg == thresh_reg - 32'd1) begin
            tick_cnt_reg <= '0;
            thresh_reg   <= thresh_now;
            if (landed) begin
              state_reg <= LOCK;
              lock_reg  <= 1'b1;
            end else begin
              fall_tick_reg <= 1'b1;
            end
          end else begin
            tick_cnt_reg <= tick_cnt_reg + 32'd1;
          end
        end
        LOCK: begin
          scan_row_reg <= BOTTOM_ROW;
          state_reg    <= SCAN;
        end
        SCAN: begin
          if (row_full) begin
            state_reg     <= CLEAR;
            clear_row_reg <= 1'b1;
          end else if (scan_row_reg == 5'd0) begin
            state_reg    <= SPAWN;
            spawn_reg    <= 1'b1;
            shape_id_reg <= lfsr_shape;
          end else begin
            scan_row_reg <= scan_row_reg - 5'd1;
          end
        end
        CLEAR: begin
          // Stay on the same row: the rows above have shifted into it.
          if (clear_ack) begin
            clear_row_reg <= 1'b0;
            state_reg     <= SCAN;
            if (lines_reg != 16'hFFFF) lines_reg <= lines_reg + 16'd1;
            if (lvl_cnt_reg == LVL_WRAP) begin
              lvl_cnt_reg <= '0;
              if (level_reg < LVL_TOP) level_reg <= level_reg + 4'd1;
            end else begin
              lvl_cnt_reg <= lvl_cnt_reg + 16'd1;
            end
          end
        end
        GAME_OVER: begin
          if (start) begin
            lines_reg     <= '0;
            level_reg     <= 4'd1;
            lvl_cnt_reg   <= '0;
            game_over_reg <= 1'b0;
            state_reg     <= SPAWN;
            spawn_reg     <= 1'b1;
            shape_id_reg  <= lfsr_shape;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign spawn     = spawn_reg;
  assign shape_id  = shape_id_reg;
  assign fall_tick = fall_tick_reg;
  assign lock      = lock_reg;
  assign scan_row  = scan_row_reg;
  assign clear_row = clear_row_reg;
  assign lines     = lines_reg;
  assign level     = level_reg;
  assign game_over = game_over_reg;

endmodule

// File: tb/tb_tetris_game_sequencer.sv
// Randomised bench for tetris_game_sequencer with a game-level reference model,
// a toy board that feeds row_full, and literal pins for shapes, periods and reset.
module tb_tetris_game_sequencer;

  localparam int NR = 4, BASE = 10, STEP = 2, MINP = 4, LPL = 2, MAXL = 15;

  logic        iVGA_CLK = 1'b0, reset = 1'b1;
  logic        start = 1'b0, landed = 1'b0, spawn_blocked = 1'b0;
  logic        row_full = 1'b0, clear_ack = 1'b0, soft_drop = 1'b1;
  logic        spawn, fall_tick, lock, clear_row, game_over;
  logic [3:0]  shape_id, level;
  logic [4:0]  scan_row;
  logic [15:0] lines;

  tetris_game_sequencer #(
    .TICK_BASE(BASE), .TICK_STEP(STEP), .TICK_MIN(MINP),
    .LINES_PER_LEVEL(LPL), .MAX_LEVEL(MAXL), .NUM_ROWS(NR)
  ) dut (
    .iVGA_CLK(iVGA_CLK), .reset(reset), .start(start), .landed(landed),
    .spawn_blocked(spawn_blocked), .row_full(row_full), .clear_ack(clear_ack),
    .soft_drop(soft_drop), .spawn(spawn), .shape_id(shape_id), .fall_tick(fall_tick),
    .lock(lock), .scan_row(scan_row), .clear_row(clear_row), .lines(lines),
    .level(level), .game_over(game_over)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (game-level view) ----------------
  typedef enum {P_IDLE, P_NEW, P_CHECK, P_DROP, P_LAND, P_SCAN, P_WAIT, P_DEAD} phase_t;
  phase_t phase;
  int m_lfsr, m_lines, remain, e_row, e_shape;
  bit e_spawn, e_tick, e_lock, e_clr, e_over;
  bit board[NR];
  int k_landed = 0, k_block = 0, k_ack = 0, k_start = 0, k_fill = 0, k_soft = 0;

  function automatic int lfsr_step(input int x);
    int fb;
    int taps[4];
    taps = '{16, 14, 13, 11};
    fb = 0;
    foreach (taps[i]) fb ^= (x >> (16 - taps[i])) & 1;
    return (x >> 1) | (fb << 15);
  endfunction

  function automatic int shape_of(input int v);
    if (v == 0) return 14;
    if (v == 15) return 1;
    return v;
  endfunction

  function automatic int exp_level();
    int v;
    v = 1 + m_lines / LPL;
    return (v > MAXL) ? MAXL : v;
  endfunction

  function automatic int thresh_of();
    int p;
    p = BASE - (exp_level() - 1) * STEP;
    if (p < MINP) p = MINP;
`ifdef TETRIS_SOFT_DROP_EN
    if (!soft_drop) p = ((p >> 3) < 1) ? 1 : (p >> 3);
`endif
    return p;
  endfunction

  task automatic model_reset();
    phase = P_IDLE; m_lfsr = 'hACE1; m_lines = 0; remain = 0;
    e_row = NR - 1; e_shape = 1;
    e_spawn = 0; e_tick = 0; e_lock = 0; e_clr = 0; e_over = 0;
    foreach (board[i]) board[i] = 0;
  endtask

  task automatic new_piece();
    phase = P_NEW; e_spawn = 1; e_shape = shape_of(m_lfsr & 15);
  endtask

  task automatic model_step();
    e_spawn = 0; e_tick = 0; e_lock = 0;
    case (phase)
      P_IDLE:  if (start) new_piece();
      P_NEW:   begin m_lfsr = lfsr_step(m_lfsr); phase = P_CHECK; end
      P_CHECK: if (spawn_blocked) begin phase = P_DEAD; e_over = 1; end
               else begin phase = P_DROP; remain = thresh_of(); end
      P_DROP: begin
        remain--;
        if (remain == 0) begin
          remain = thresh_of();
          if (landed) begin phase = P_LAND; e_lock = 1; end
          else e_tick = 1;
        end
      end
      P_LAND: begin
        phase = P_SCAN; e_row = NR - 1;
        foreach (board[i]) if ($urandom_range(99) < k_fill) board[i] = 1;
      end
      P_SCAN: begin
        if (row_full) begin phase = P_WAIT; e_clr = 1; end
        else if (e_row == 0) new_piece();
        else e_row--;
      end
      P_WAIT: if (clear_ack) begin
        e_clr = 0; phase = P_SCAN;
        if (m_lines < 65535) m_lines++;
        for (int r = e_row; r > 0; r--) board[r] = board[r-1];
        board[0] = 0;
      end
      P_DEAD: if (start) begin m_lines = 0; e_over = 0; new_piece(); end
      default: phase = P_IDLE;
    endcase
  endtask

  always @(posedge iVGA_CLK or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  int cyc = 0, last_tick = -1, lvl15_checks = 0, max_level = 0;
  always @(negedge iVGA_CLK) begin
    cyc++;
    if (chk_en && !reset && errors < 50) begin
      chk("spawn", spawn, e_spawn);
      chk("shape_id", shape_id, e_shape);
      chk("fall_tick", fall_tick, e_tick);
      chk("lock", lock, e_lock);
      chk("scan_row", scan_row, e_row);
      chk("clear_row", clear_row, e_clr);
      chk("lines", lines, m_lines);
      chk("level", level, exp_level());
      chk("game_over", game_over, e_over);
      if (int'(level) > max_level) max_level = int'(level);
      if (spawn) last_tick = -1;
      if (fall_tick) begin
        if (last_tick >= 0 && level == 4'd15 && lvl15_checks < 5 && soft_drop) begin
          chk("tick_period_lvl15", cyc - last_tick, 4);
          lvl15_checks++;
        end
        last_tick = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit force_start);
    @(negedge iVGA_CLK);
    start         = force_start || ($urandom_range(99) < k_start);
    landed        = $urandom_range(99) < k_landed;
    spawn_blocked = $urandom_range(99) < k_block;
    clear_ack     = $urandom_range(99) < k_ack;
    soft_drop     = !($urandom_range(99) < k_soft);
    row_full      = board[e_row];
  endtask

  task automatic wait_pulse(input int sel, input int bound, input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      drive(0);
      case (sel)
        0: seen = spawn;
        1: seen = fall_tick;
        2: seen = lock;
        default: seen = clear_row;
      endcase
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no pulse within %0d cycles", nm, bound);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_spawn"}, spawn, 0);
    chk({tag, "_fall_tick"}, fall_tick, 0);
    chk({tag, "_lock"}, lock, 0);
    chk({tag, "_clear_row"}, clear_row, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_lines"}, lines, 0);
    chk({tag, "_level"}, level, 1);
    chk({tag, "_scan_row"}, scan_row, NR - 1);
    chk({tag, "_shape_id"}, shape_id, 1);
  endtask

  initial begin
    time t0;
    bit found;
    repeat (3) @(negedge iVGA_CLK);
    check_reset_values("reset");
    reset = 1'b0;
    chk_en = 1;

    // First piece: spawn the cycle after start, seed nibble gives shape 1.
    drive(1);
    drive(0);
    chk("first_spawn", spawn, 1);
    chk("first_shape", shape_id, 1);
    wait_pulse(1, 20, "first_tick");
    t0 = $time;
    wait_pulse(1, 20, "second_tick");
    chk("tick_period_lvl1", (($time - t0) / 10), 10);

    // Landing on an empty board: lock, scan 3..0, respawn with the next shapes.
    k_landed = 100;
    wait_pulse(2, 15, "lock_1");
    wait_pulse(0, 15, "respawn_1");
    chk("shape_2nd", shape_id, 14);
    wait_pulse(2, 20, "lock_2");
    wait_pulse(0, 15, "respawn_2");
    chk("shape_3rd", shape_id, 8);

    // Random play: clears, level ramp, game over and restart.
    k_landed = 30; k_block = 1; k_ack = 40; k_start = 2; k_fill = 35; k_soft = 0;
    repeat (20000) drive(0);
    chk("max_level_reached", max_level, 15);

    // Reset in the middle of a clear handshake.
    k_ack = 0; k_fill = 100; k_landed = 100; k_block = 0; k_start = 0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      drive(phase == P_IDLE || phase == P_DEAD);
      found = e_clr;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_clear: CLEAR not reached within 300 cycles");
    end
    drive(0);
    drive(0);
    chk("clear_row_held", clear_row, 1);
    #2;
    chk_en = 0;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    k_ack = 0; k_fill = 0; k_landed = 0;
    @(negedge iVGA_CLK);
    @(negedge iVGA_CLK);
    reset = 1'b0;
    chk_en = 1;

`ifdef TETRIS_SOFT_DROP_EN
    k_soft = 100;
    drive(1);
    wait_pulse(1, 20, "soft_tick");
    drive(0);
    chk("soft_drop_every_clock", fall_tick, 1);
`endif
    drive(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
